// File: rtl/mux_rr_nto1.sv
// N-to-1 data selector with a registered output stage and valid/ready handshakes.
// The winner is either an explicit channel index or a round-robin pick among requesters.
module mux_rr_nto1 #(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int sel_w    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mode_i,
  input  logic [sel_w-1:0]           select_i,
  input  logic [channels-1:0]        valid_i,
  input  logic [channels*size-1:0]   data_i,
  output logic [channels-1:0]        ready_o,
  output logic                       valid_o,
  output logic [size-1:0]            data_o,
  output logic [sel_w-1:0]           grant_o,
  input  logic                       ready_i
);

  // Channel tables padded to the full select range, so an index past the last
  // channel reads as "not requesting" rather than going out of bounds.
  localparam int slots = 2 ** sel_w;

  logic [slots-1:0] valid_ext;
  logic [size-1:0]  data_arr [slots];
  logic [sel_w-1:0] ptr;
  logic [sel_w-1:0] win;
  logic [sel_w-1:0] idx;
  logic             grant;
  logic             load_en;
  logic             xfer;

  always_comb begin
    valid_ext                 = '0;
    valid_ext[channels-1:0]   = valid_i;
    for (int k = 0; k < slots; k++) begin
      data_arr[k] = '0;
    end
    for (int k = 0; k < channels; k++) begin
      data_arr[k] = data_i[k*size +: size];
    end
  end

  // Scan starts one past the last round-robin winner and wraps modulo channels.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    win   = '0;
    grant = 1'b0;
    idx   = '0;
    if (!mode_i) begin
      win   = select_i;
      grant = valid_ext[select_i];
    end else begin
      for (int i = 1; i <= channels; i++) begin
        idx = sel_w'((int'(ptr) + i) % channels);
        if (!grant && valid_ext[idx]) begin
          grant = 1'b1;
          win   = idx;
        end
      end
    end
  end

  assign load_en = !valid_o || ready_i;
  assign xfer    = grant && load_en;

  always_comb begin
    ready_o = '0;
    if (xfer && !rst_i) begin
      ready_o = channels'(1) << win;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      grant_o <= '0;
      ptr     <= sel_w'(channels - 1);
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= data_arr[win];
      grant_o <= win;
      if (mode_i) begin
        ptr <= win;
      end
    end else if (ready_i) begin
      // Drain with nothing to replace it: data and grant keep their last values.
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed self-checking bench for mux_rr_nto1 (4 channels x 32 bits).
// Inputs change 2 time units after a rising edge; outputs are checked away from the edge.
module tb_mux_rr_nto1;

  localparam int size     = 32;
  localparam int channels = 4;
  localparam int sel_w    = 2;

  logic                     clk_i;
  logic                     rst_i;
  logic                     mode_i;
  logic [sel_w-1:0]         select_i;
  logic [channels-1:0]      valid_i;
  logic [channels*size-1:0] data_i;
  logic [channels-1:0]      ready_o;
  logic                     valid_o;
  logic [size-1:0]          data_o;
  logic [sel_w-1:0]         grant_o;
  logic                     ready_i;

  int n_checks;
  int n_fails;

  mux_rr_nto1 #(.size(size), .channels(channels), .sel_w(sel_w)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mode_i   (mode_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .grant_o  (grant_o),
    .ready_i  (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_data(input int k, input logic [size-1:0] val);
    data_i[k*size +: size] = val;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mode_i = 1'b1; select_i = '0; valid_i = 4'b1111; ready_i = 1'b1;
    for (int k = 0; k < channels; k++) set_data(k, 32'(k));
    #1;
    n_checks++;
    if (ready_o !== 4'b0000) begin n_fails++; $display("FAIL reset_ready: got %b want %b", ready_o, 4'b0000); end
    step();
    step();
    n_checks++;
    if (ready_o !== 4'b0000) begin n_fails++; $display("FAIL reset_ready_held: got %b want %b", ready_o, 4'b0000); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fails++; $display("FAIL reset_data: got %h want 0", data_o); end
    n_checks++;
    if (grant_o !== 2'd0) begin n_fails++; $display("FAIL reset_grant: got %0d want 0", grant_o); end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 4'b0001) begin n_fails++; $display("FAIL reset_first_ready: got %b want %b", ready_o, 4'b0001); end
    step();
    n_checks++;
    if (grant_o !== 2'd0 || valid_o !== 1'b1) begin
      n_fails++; $display("FAIL reset_first_grant: got grant %0d valid %b want grant 0 valid 1", grant_o, valid_o);
    end
  endtask

  // Enters with ptr=0 (last round-robin grant was ch0).
  task automatic test_explicit();
    mode_i = 1'b0; select_i = 2'd2; valid_i = 4'b0100; ready_i = 1'b1;
    set_data(2, 32'hCAFE0002);
    #1;
    n_checks++;
    if (ready_o !== 4'b0100) begin n_fails++; $display("FAIL explicit_ready: got %b want %b", ready_o, 4'b0100); end
    step();
    n_checks++;
    if (data_o !== 32'hCAFE0002 || grant_o !== 2'd2 || valid_o !== 1'b1) begin
      n_fails++; $display("FAIL explicit_out: got data %h grant %0d valid %b want cafe0002 2 1", data_o, grant_o, valid_o);
    end
    valid_i = 4'b1011;
    #1;
    n_checks++;
    if (ready_o !== 4'b0000) begin n_fails++; $display("FAIL explicit_nogrant_ready: got %b want %b", ready_o, 4'b0000); end
    step();
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 32'hCAFE0002 || grant_o !== 2'd2) begin
      n_fails++; $display("FAIL explicit_drain: got valid %b data %h grant %0d want 0 cafe0002 2", valid_o, data_o, grant_o);
    end
    // Explicit transfer must not have moved ptr: round-robin now picks ch1.
    mode_i = 1'b1; valid_i = 4'b1111;
    #1;
    n_checks++;
    if (ready_o !== 4'b0010) begin n_fails++; $display("FAIL explicit_ptr_kept: got %b want %b", ready_o, 4'b0010); end
    valid_i = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; mode_i = 1'b1; valid_i = 4'b1111; ready_i = 1'b1;
    for (int k = 0; k < channels; k++) set_data(k, 32'(k));
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (grant_o !== 2'(i % 4) || valid_o !== 1'b1 || data_o !== 32'(i % 4)) begin
        n_fails++;
        $display("FAIL rr_seq[%0d]: got grant %0d valid %b data %h want grant %0d valid 1", i, grant_o, valid_o, data_o, i % 4);
      end
    end
  endtask

  // Enters with ptr=1.
  task automatic test_skip_wrap();
    logic [sel_w-1:0] exp_g [3];
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0;
    valid_i = 4'b0100;
    step();
    n_checks++;
    if (grant_o !== 2'd2) begin n_fails++; $display("FAIL wrap_setup: got %0d want 2", grant_o); end
    valid_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (grant_o !== exp_g[i] || data_o !== 32'(exp_g[i])) begin
        n_fails++; $display("FAIL wrap[%0d]: got grant %0d data %h want %0d", i, grant_o, data_o, exp_g[i]);
      end
    end
  endtask

  // Enters with ptr=0.
  task automatic test_backpressure();
    valid_i = 4'b0010; ready_i = 1'b1;
    set_data(1, 32'h11);
    set_data(2, 32'h22);
    step();
    n_checks++;
    if (data_o !== 32'h11 || grant_o !== 2'd1) begin
      n_fails++; $display("FAIL bp_setup: got data %h grant %0d want 11 1", data_o, grant_o);
    end
    ready_i = 1'b0; valid_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ready_o !== 4'b0000) begin n_fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready_o); end
      step();
      n_checks++;
      if (data_o !== 32'h11 || valid_o !== 1'b1 || grant_o !== 2'd1) begin
        n_fails++; $display("FAIL bp_hold[%0d]: got data %h valid %b grant %0d want 11 1 1", i, data_o, valid_o, grant_o);
      end
    end
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 4'b0100) begin n_fails++; $display("FAIL bp_release_ready: got %b want %b", ready_o, 4'b0100); end
    step();
    n_checks++;
    if (data_o !== 32'h22 || grant_o !== 2'd2 || valid_o !== 1'b1) begin
      n_fails++; $display("FAIL bp_release_out: got data %h grant %0d valid %b want 22 2 1", data_o, grant_o, valid_o);
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; valid_i = 4'b1111; rst_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 4'b0000) begin n_fails++; $display("FAIL midrst_ready: got %b want 0000", ready_o); end
    step();
    rst_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || grant_o !== 2'd0) begin
      n_fails++; $display("FAIL midrst_out: got valid %b data %h grant %0d want 0 0 0", valid_o, data_o, grant_o);
    end
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 4'b0001) begin n_fails++; $display("FAIL midrst_ready_after: got %b want 0001", ready_o); end
    step();
    n_checks++;
    if (grant_o !== 2'd0 || valid_o !== 1'b1 || data_o !== 32'h0) begin
      n_fails++; $display("FAIL midrst_grant: got grant %0d valid %b data %h want 0 1 0", grant_o, valid_o, data_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    data_i   = '0;
    test_reset();
    test_explicit();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_rr_nto1.md
Name: mux_rr_nto1

Overview:
- Parametrised N-to-1 data selector with a registered output stage and a valid/ready handshake on every input channel and on the output.
- Two modes:
  - Explicit select: picks the channel named by select_i, like the existing 4-to-1 mux.
  - Round-robin: arbitrates fairly among all requesting channels.
- Sits between multiple requesters (e.g. I-side/D-side miss paths) and a shared consumer (e.g. the cache refill/memory port).

Parameters:
- size, 32, width in bits of each data channel and of data_o.
- channels, 4, number of input channels; 2 to 16.
- sel_w, 2, width of select_i and grant_o; must equal ceil(log2(channels)).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mode_i  input  1  0 = explicit select, 1 = round-robin.
- select_i  input  sel_w  channel index used when mode_i=0.
- valid_i  input  channels  per-channel request; bit k qualifies channel k.
- data_i  input  channels*size  channel k occupies bits [k*size +: size].
- ready_o  output  channels  one-hot accept; bit k high means channel k transfers this cycle.
- valid_o  output  1  output register holds a valid word.
- data_o  output  size  registered selected data.
- grant_o  output  sel_w  index of the channel whose data is in data_o.
- ready_i  input  1  consumer accepts data_o this cycle.

Behaviour:
- **Reset** (rst_i=1 at clock edge):
  - valid_o=0, data_o=0, grant_o=0.
  - Round-robin pointer ptr=channels-1, so channel 0 has first priority.
  - Any held word is discarded.
  - ready_o is forced to 0 while rst_i=1.
- **Load enable:** load_en = !valid_o || ready_i. The output register accepts a new word when empty or draining in the same cycle.
- **Explicit mode** (mode_i=0):
  - Candidate win = select_i.
  - Grant exists only if select_i < channels and valid_i[select_i]=1.
  - Indices >= channels never grant; ready_o=0.
- **Round-robin mode** (mode_i=1):
  - Scan channels ptr+1, ptr+2, … modulo channels; the first channel with valid_i set wins.
  - If no valid_i is set, there is no grant.
- **ready_o:** one-hot of the winner ANDed with load_en. It is combinational from valid_i, select_i, mode_i and state; valid_i never depends on ready_o.
- **Transfer:** occurs when a grant exists and load_en=1. On the next edge:
  - data_o takes the winner's data, grant_o takes win, valid_o=1.
  - In round-robin mode only, ptr takes win.
- **Drain without new transfer** (valid_o && ready_i, no grant): valid_o clears. data_o and grant_o hold their last values.
- **Stall** (valid_o && !ready_i): data_o, grant_o and valid_o are held stable; ready_o=0 on all bits.
- **Throughput and latency:** one word per cycle with ready_i tied high. Latency is 1 cycle from the accepting edge to valid_o.
- **ptr updates:**
  - ptr changes only on a round-robin-mode transfer.
  - Explicit-mode transfers leave ptr untouched.
  - A mode switch takes effect on the same cycle's arbitration and preserves ptr.
- **Fairness:** with all channels requesting continuously in round-robin mode, grants follow 0,1,…,channels-1,0,… with no channel starved.
- **Wrap-around:** ptr=channels-1 wraps the scan to channel 0.
- **Simultaneous drain and load:** the old word leaves and the new word enters on the same edge; valid_o stays 1.
- **Reset mid-operation:** a held word is dropped, and no transfer is acknowledged in the reset cycle.

Test Plan:
- **Reset:**
  - Stimulus: assert rst_i for 2 cycles with valid_i=4'b1111, ready_i=1.
  - Required: ready_o=0; next cycle valid_o=0, data_o=0, grant_o=0.
  - Required: first round-robin grant after release is channel 0.
- **Explicit mode:**
  - Stimulus: mode_i=0, select_i=2, valid_i=4'b0100, data ch2=32'hCAFE0002, ready_i=1.
  - Required: ready_o=4'b0100 in that cycle; next cycle data_o=32'hCAFE0002, grant_o=2, valid_o=1.
  - Stimulus: select_i=2 with valid_i=4'b1011. Required: no grant, ready_o=0.
- **Round-robin fairness:**
  - Stimulus: mode_i=1, valid_i=4'b1111 held, ch k data=k, ready_i=1.
  - Required: grant_o sequence 0,1,2,3,0,1 on consecutive cycles, valid_o continuously 1.
- **Skip and wrap:**
  - Stimulus: mode_i=1, ptr=2 (last grant ch2), valid_i=4'b0011.
  - Required: grant ch0, then ch1, then ch0.
- **Backpressure:**
  - Stimulus: valid_o=1 holding 32'h11, ready_i=0 for 3 cycles while valid_i=4'b1111.
  - Required: ready_o=0 and data_o=32'h11 stable.
  - Stimulus: ready_i=1 in cycle 4. Required: ready_o one-hot at the next round-robin channel, and the new word appears the following cycle.
- **Reset mid-operation:**
  - Stimulus: rst_i pulsed while valid_o=1, ready_i=0.
  - Required: next cycle valid_o=0, data_o=0, ptr back to channels-1 (next round-robin grant ch0).
